// File: rtl/pilot_avg_if.sv
// pilot_avg_if: sample-in / estimate-out bus of the pilot averaging bank.
interface pilot_avg_if #(
  parameter int WIDTH_PILOT = 16,
  parameter int WIDTH_EST = 17,
  parameter int NUM_SUB = 4
);
  localparam int AW = $clog2(NUM_SUB);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_addr;
  logic signed [WIDTH_PILOT-1:0] in_re;
  logic signed [WIDTH_PILOT-1:0] in_im;
  logic [AW-1:0] rd_addr;
  logic signed [WIDTH_EST-1:0] rd_re;
  logic signed [WIDTH_EST-1:0] rd_im;
  logic [NUM_SUB-1:0] slot_vld;
  logic done;
  logic err;
  modport master (
    output start, in_valid, in_addr, in_re, in_im, rd_addr,
    input in_ready, rd_re, rd_im, slot_vld, done, err
  );
  modport slave (
    input start, in_valid, in_addr, in_re, in_im, rd_addr,
    output in_ready, rd_re, rd_im, slot_vld, done, err
  );
endinterface

// File: rtl/pilot_avg_bank.sv
// pilot_avg_bank: per-slot complex pilot averaging over 2^LOG2_NAVG samples.
// Define AVG_ROUND_EN to round half toward +inf instead of flooring.
module pilot_avg_bank #(
  parameter int WIDTH_PILOT = 16,
  parameter int WIDTH_EST = 17,
  parameter int NUM_SUB = 4,
  parameter int LOG2_NAVG = 1
) (
  input logic clk,
  input logic rst,
  pilot_avg_if.slave bus
);
  localparam int ACW = WIDTH_PILOT + LOG2_NAVG;
  localparam int CW = LOG2_NAVG + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_NAVG) - 1);
`ifdef AVG_ROUND_EN
  localparam logic signed [ACW-1:0] RND = ACW'((1 << LOG2_NAVG) >> 1);
`else
  localparam logic signed [ACW-1:0] RND = '0;
`endif
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, next;
  logic signed [ACW-1:0] acc_re [NUM_SUB];
  logic signed [ACW-1:0] acc_im [NUM_SUB];
  logic [CW-1:0] cnt [NUM_SUB];
  logic signed [WIDTH_EST-1:0] est_re [NUM_SUB];
  logic signed [WIDTH_EST-1:0] est_im [NUM_SUB];
  logic accept, in_range, hit, commit, last, rd_ok;
  logic [NUM_SUB-1:0] sel;
  logic signed [ACW-1:0] sum_re, sum_im, sh_re, sh_im;
  assign bus.in_ready = state == ACC;
  always_comb begin
    accept = bus.in_valid && bus.in_ready && !bus.start;
    in_range = 32'(bus.in_addr) < NUM_SUB;
    rd_ok = 32'(bus.rd_addr) < NUM_SUB;
    sel = in_range ? NUM_SUB'(1) << bus.in_addr : '0;
    hit = accept && in_range && !(|(bus.slot_vld & sel));
    sum_re = acc_re[bus.in_addr] + ACW'(bus.in_re);
    sum_im = acc_im[bus.in_addr] + ACW'(bus.in_im);
    // rounding never overflows: the sum stays at least NAVG/2 below the positive limit
    sh_re = (sum_re + RND) >>> LOG2_NAVG;
    sh_im = (sum_im + RND) >>> LOG2_NAVG;
    commit = hit && cnt[bus.in_addr] == LAST;
    last = commit && &(bus.slot_vld | sel);
    next = bus.start ? ACC : (state == ACC && last) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SUB; i++) begin
        acc_re[i] <= '0;
        acc_im[i] <= '0;
        cnt[i] <= '0;
        est_re[i] <= '0;
        est_im[i] <= '0;
      end
      bus.slot_vld <= '0;
      bus.err <= 1'b0;
      bus.done <= 1'b0;
      bus.rd_re <= '0;
      bus.rd_im <= '0;
    end else begin
      bus.done <= last;
      bus.rd_re <= (bus.start || !rd_ok) ? '0 : est_re[bus.rd_addr];
      bus.rd_im <= (bus.start || !rd_ok) ? '0 : est_im[bus.rd_addr];
      if (bus.start) begin
        for (int i = 0; i < NUM_SUB; i++) begin
          acc_re[i] <= '0;
          acc_im[i] <= '0;
          cnt[i] <= '0;
          est_re[i] <= '0;
          est_im[i] <= '0;
        end
        bus.slot_vld <= '0;
        bus.err <= 1'b0;
      end else begin
        if (accept && !hit) bus.err <= 1'b1;
        if (commit) begin
          est_re[bus.in_addr] <= WIDTH_EST'(sh_re);
          est_im[bus.in_addr] <= WIDTH_EST'(sh_im);
          bus.slot_vld <= bus.slot_vld | sel;
          acc_re[bus.in_addr] <= '0;
          acc_im[bus.in_addr] <= '0;
          cnt[bus.in_addr] <= '0;
        end else if (hit) begin
          acc_re[bus.in_addr] <= sum_re;
          acc_im[bus.in_addr] <= sum_im;
          cnt[bus.in_addr] <= cnt[bus.in_addr] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pilot_avg_bank.sv
// tb_pilot_avg_bank: directed table-driven checks of pilot_avg_bank.
module tb_pilot_avg_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
`ifdef AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  pilot_avg_if #(.WIDTH_PILOT(16), .WIDTH_EST(17), .NUM_SUB(4)) bus ();
  pilot_avg_bank #(.WIDTH_PILOT(16), .WIDTH_EST(17), .NUM_SUB(4), .LOG2_NAVG(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  pilot_avg_if #(.WIDTH_PILOT(16), .WIDTH_EST(17), .NUM_SUB(3)) bus2 ();
  pilot_avg_bank #(.WIDTH_PILOT(16), .WIDTH_EST(17), .NUM_SUB(3), .LOG2_NAVG(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));
  typedef struct {
    int addr;
    int re;
    int im;
    int vld;
    int dn;
  } vec_t;
  typedef struct {
    int re_f;
    int re_r;
    int im_f;
    int im_r;
  } rd_t;
  vec_t vecs [8];
  rd_t rds [4];
  int pass_n = 0;
  int total_n = 0;
  task automatic chk(string name, int act, int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic drive(bit v, int a, int re, int im, bit st);
    bus.in_valid = v;
    bus.in_addr = 2'(a);
    bus.in_re = 16'(re);
    bus.in_im = 16'(im);
    bus.start = st;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic drive2(bit v, int a, int re, int im, bit st);
    bus2.in_valid = v;
    bus2.in_addr = 2'(a);
    bus2.in_re = 16'(re);
    bus2.in_im = 16'(im);
    bus2.start = st;
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus2.start = 1'b0;
  endtask
  task automatic rd(string n, int s, int er, int ei);
    bus.rd_addr = 2'(s);
    @(posedge clk);
    @(negedge clk);
    chk({n, "_re"}, int'(bus.rd_re), er);
    chk({n, "_im"}, int'(bus.rd_im), ei);
  endtask
  initial begin
    vecs[0] = '{2, 32767, -32768, 0, 0};
    vecs[1] = '{1, -32768, 32767, 0, 0};
    vecs[2] = '{2, 32767, -32768, 4, 0};
    vecs[3] = '{3, 100, -100, 4, 0};
    vecs[4] = '{0, 5, 6, 4, 0};
    vecs[5] = '{1, -32768, 32767, 6, 0};
    vecs[6] = '{3, -7, 7, 14, 0};
    vecs[7] = '{0, 1, 1, 15, 1};
    rds[0] = '{3, 3, 3, 4};
    rds[1] = '{-32768, -32768, 32767, 32767};
    rds[2] = '{32767, 32767, -32768, -32768};
    rds[3] = '{46, 47, -47, -46};
    {bus.start, bus.in_valid, bus.in_addr, bus.in_re, bus.in_im, bus.rd_addr} = '0;
    {bus2.start, bus2.in_valid, bus2.in_addr, bus2.in_re, bus2.in_im, bus2.rd_addr} = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_slot_vld", int'(bus.slot_vld), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_rd_re", int'(bus.rd_re), 0);
    rst = 1'b1;
    drive(1, 0, 3, -3, 0);
    chk("idle_err", int'(bus.err), 0);
    chk("idle_vld", int'(bus.slot_vld), 0);
    chk("idle_ready", int'(bus.in_ready), 0);
    drive(0, 0, 0, 0, 1);
    chk("start_ready", int'(bus.in_ready), 1);
    chk("start_vld", int'(bus.slot_vld), 0);
    drive(1, 0, 3, -3, 0);
    chk("basic_vld0", int'(bus.slot_vld), 0);
    drive(1, 0, 4, -4, 0);
    chk("basic_vld1", int'(bus.slot_vld), 1);
    rd("basic", 0, RND ? 4 : 3, RND ? -3 : -4);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, vecs[i].addr, vecs[i].re, vecs[i].im, 0);
      chk($sformatf("ilv%0d_vld", i), int'(bus.slot_vld), vecs[i].vld);
      chk($sformatf("ilv%0d_done", i), int'(bus.done), vecs[i].dn);
    end
    chk("ilv_ready", int'(bus.in_ready), 0);
    drive(1, 1, 9, 9, 0);
    chk("ilv_done_once", int'(bus.done), 0);
    chk("ilv_done_noerr", int'(bus.err), 0);
    for (int s = 0; s < 4; s++)
      rd($sformatf("ilv_rd%0d", s), s, RND ? rds[s].re_r : rds[s].re_f, RND ? rds[s].im_r : rds[s].im_f);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 2, 2, 0);
    drive(1, 0, 4, 4, 0);
    drive(1, 0, 100, 100, 0);
    chk("drop_err", int'(bus.err), 1);
    chk("drop_vld", int'(bus.slot_vld), 1);
    rd("drop", 0, 3, 3);
    drive(1, 1, 50, 50, 0);
    drive(1, 1, 50, 50, 1);
    chk("restart_vld", int'(bus.slot_vld), 0);
    chk("restart_err", int'(bus.err), 0);
    chk("restart_ready", int'(bus.in_ready), 1);
    for (int s = 0; s < 4; s++) rd($sformatf("restart_rd%0d", s), s, 0, 0);
    drive(1, 1, 8, 8, 0);
    chk("restart_half", int'(bus.slot_vld), 0);
    drive(1, 1, 9, -9, 0);
    chk("restart_commit", int'(bus.slot_vld), 2);
    rd("restart_avg", 1, RND ? 9 : 8, RND ? 0 : -1);
    drive(1, 1, 1, 1, 0);
    chk("pre_rst_err", int'(bus.err), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", int'(bus.in_ready), 0);
    chk("arst_vld", int'(bus.slot_vld), 0);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_rd_re", int'(bus.rd_re), 0);
    chk("arst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 2, 5, 5, 0);
    chk("post_rst_ready", int'(bus.in_ready), 0);
    chk("post_rst_vld", int'(bus.slot_vld), 0);
    chk("post_rst_done", int'(bus.done), 0);
    drive2(0, 0, 0, 0, 1);
    drive2(1, 3, 11, 11, 0);
    chk("oor_err", int'(bus2.err), 1);
    chk("oor_vld", int'(bus2.slot_vld), 0);
    drive2(1, 2, -5, 7, 0);
    chk("n1_vld", int'(bus2.slot_vld), 4);
    bus2.rd_addr = 2'd2;
    @(posedge clk);
    @(negedge clk);
    chk("n1_rd_re", int'(bus2.rd_re), -5);
    chk("n1_rd_im", int'(bus2.rd_im), 7);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
